// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between a single-cycle primary writeback
// path and a FIFO-buffered multi-cycle producer, with RAW hazard tracking.
// Latency: primary 1 cycle, secondary >= 2 cycles; mc_ready = !full, primary stalls only on starvation.
module rf_write_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_stall,
    input  logic              mc_valid,
    output logic              mc_ready,
    input  logic [ADDR_W-1:0] mc_reg,
    input  logic [DATA_W-1:0] mc_data,
    input  logic [ADDR_W-1:0] rd_reg1,
    input  logic [ADDR_W-1:0] rd_reg2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    output logic              reg_write,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic              live_q [DEPTH];
    logic              live_k [DEPTH];
    logic              live_d [DEPTH];
    logic [ADDR_W-1:0] reg_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              wb_stall_q, wb_stall_d;
    logic              err_q, err_d;
    logic              reg_write_q, reg_write_d;
    logic [ADDR_W-1:0] write_reg_q, write_reg_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;

    logic empty, full, push, pop, prim_sel, kill, head_live;
    logic busy1, busy2;

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);
    assign mc_ready  = !full && !reset;
    assign push      = mc_valid && mc_ready;
    assign prim_sel  = wb_valid && !wb_stall_q;
    // A forced stall hands the cycle to the head even if the primary misbehaves.
    assign pop       = !empty && (wb_stall_q || !wb_valid);
    assign kill      = prim_sel && (wb_reg != '0);
    assign head_live = !empty && live_q[rd_ptr_q];

    // Live bits after the same-cycle primary kill; hazards and next state both use these.
    always_comb begin
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            live_k[i] = live_q[i];
            if (kill && (reg_q[i] == wb_reg)) begin
                live_k[i] = 1'b0;
            end
            if (live_k[i] && (reg_q[i] == rd_reg1)) begin
                busy1 = 1'b1;
            end
            if (live_k[i] && (reg_q[i] == rd_reg2)) begin
                busy2 = 1'b1;
            end
        end
    end

    assign rd_busy1 = busy1 && (rd_reg1 != '0) && !reset;
    assign rd_busy2 = busy2 && (rd_reg2 != '0) && !reset;

    // The push lands after the kill so a newer buffered write to the same reg survives.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            live_d[i] = live_k[i];
        end
        if (pop) begin
            live_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            live_d[wr_ptr_q] = (mc_reg != '0);
        end
    end

    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        err_d    = err_q || (wb_stall_q && wb_valid);

        reg_write_d  = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        if (pop) begin
            reg_write_d  = live_q[rd_ptr_q];
            write_reg_d  = reg_q[rd_ptr_q];
            write_data_d = data_q[rd_ptr_q];
        end else if (prim_sel) begin
            reg_write_d  = (wb_reg != '0);
            write_reg_d  = wb_reg;
            write_data_d = wb_data;
        end

        if (pop || empty) begin
            starve_d = '0;
        end else if (head_live && prim_sel && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
        wb_stall_d = (starve_d == STARVE_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            starve_q     <= '0;
            wb_stall_q   <= 1'b0;
            err_q        <= 1'b0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                live_q[i] <= 1'b0;
            end
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            starve_q     <= starve_d;
            wb_stall_q   <= wb_stall_d;
            err_q        <= err_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            for (int i = 0; i < DEPTH; i++) begin
                live_q[i] <= live_d[i];
            end
        end
    end

    // Payload storage needs no reset: an entry is only meaningful while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            reg_q[wr_ptr_q]  <= mc_reg;
            data_q[wr_ptr_q] <= mc_data;
        end
    end

    assign wb_stall   = wb_stall_q;
    assign err        = err_q;
    assign reg_write  = reg_write_q;
    assign write_reg  = write_reg_q;
    assign write_data = write_data_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: primary, secondary, fill, WAW kill,
// starvation and mid-operation reset.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        wb_stall;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_reg;
    logic [31:0] mc_data;
    logic [4:0]  rd_reg1, rd_reg2;
    logic        rd_busy1, rd_busy2;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic        err;

    int n_pass  = 0;
    int n_total = 0;

    rf_write_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_stall(wb_stall),
        .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_reg(mc_reg), .mc_data(mc_data),
        .rd_reg1(rd_reg1), .rd_reg2(rd_reg2), .rd_busy1(rd_busy1), .rd_busy2(rd_busy2),
        .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data), .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid = 1'b0; wb_reg = '0; wb_data = '0;
        mc_valid = 1'b0; mc_reg = '0; mc_data = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        rd_reg1 = 5'd0; rd_reg2 = 5'd0;
        step(); step();
        n_total++; if (reg_write !== 1'b0) $display("FAIL reset_reg_write got %b exp 0", reg_write); else n_pass++;
        n_total++; if (write_reg !== 5'd0) $display("FAIL reset_write_reg got %0d exp 0", write_reg); else n_pass++;
        n_total++; if (write_data !== 32'd0) $display("FAIL reset_write_data got %h exp 0", write_data); else n_pass++;
        n_total++; if (wb_stall !== 1'b0) $display("FAIL reset_wb_stall got %b exp 0", wb_stall); else n_pass++;
        n_total++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else n_pass++;
        n_total++; if (mc_ready !== 1'b0) $display("FAIL reset_mc_ready got %b exp 0", mc_ready); else n_pass++;
        reset = 1'b0;
        #1;
        n_total++; if (mc_ready !== 1'b1) $display("FAIL post_reset_mc_ready got %b exp 1", mc_ready); else n_pass++;
        n_total++; if (rd_busy1 !== 1'b0 || rd_busy2 !== 1'b0) $display("FAIL reset_rd_busy got %b%b exp 00", rd_busy1, rd_busy2); else n_pass++;
        step();
    endtask

    task automatic test_primary();
        wb_valid = 1'b1; wb_reg = 5'd5; wb_data = 32'hA5A5_0001;
        step();
        n_total++; if (reg_write !== 1'b1) $display("FAIL prim_reg_write got %b exp 1", reg_write); else n_pass++;
        n_total++; if (write_reg !== 5'd5) $display("FAIL prim_write_reg got %0d exp 5", write_reg); else n_pass++;
        n_total++; if (write_data !== 32'hA5A5_0001) $display("FAIL prim_write_data got %h exp a5a50001", write_data); else n_pass++;
        wb_reg = 5'd0; wb_data = 32'h0000_00FF;
        step();
        n_total++; if (reg_write !== 1'b0) $display("FAIL prim_reg0 got %b exp 0", reg_write); else n_pass++;
        idle_inputs();
        step();
        n_total++; if (reg_write !== 1'b0) $display("FAIL prim_idle got %b exp 0", reg_write); else n_pass++;
    endtask

    task automatic test_secondary();
        mc_valid = 1'b1; mc_reg = 5'd7; mc_data = 32'h0000_1234;
        rd_reg1 = 5'd7;
        #1;
        n_total++; if (rd_busy1 !== 1'b0) $display("FAIL sec_busy_before got %b exp 0", rd_busy1); else n_pass++;
        step();
        idle_inputs();
        #1;
        n_total++; if (rd_busy1 !== 1'b1) $display("FAIL sec_busy_buffered got %b exp 1", rd_busy1); else n_pass++;
        n_total++; if (reg_write !== 1'b0) $display("FAIL sec_not_yet got %b exp 0", reg_write); else n_pass++;
        step();
        n_total++; if (reg_write !== 1'b1 || write_reg !== 5'd7 || write_data !== 32'h1234)
            $display("FAIL sec_write got %b/%0d/%h exp 1/7/1234", reg_write, write_reg, write_data); else n_pass++;
        n_total++; if (rd_busy1 !== 1'b0) $display("FAIL sec_busy_after got %b exp 0", rd_busy1); else n_pass++;
        step();
    endtask

    task automatic test_fill();
        wb_valid = 1'b1; wb_reg = 5'd1; wb_data = 32'h0000_0111;
        mc_valid = 1'b1; mc_reg = 5'd10; mc_data = 32'h0000_00A0;
        step();
        mc_reg = 5'd11; mc_data = 32'h0000_00B0;
        step();
        n_total++; if (mc_ready !== 1'b0) $display("FAIL fill_mc_ready got %b exp 0", mc_ready); else n_pass++;
        n_total++; if (write_reg !== 5'd1) $display("FAIL fill_prim_wins got %0d exp 1", write_reg); else n_pass++;
        idle_inputs();
        step();
        n_total++; if (write_reg !== 5'd10 || write_data !== 32'hA0) $display("FAIL fill_pop_a got %0d/%h exp 10/a0", write_reg, write_data); else n_pass++;
        n_total++; if (mc_ready !== 1'b1) $display("FAIL fill_ready_cnt1 got %b exp 1", mc_ready); else n_pass++;
        mc_valid = 1'b1; mc_reg = 5'd12; mc_data = 32'h0000_00C0;
        step();
        idle_inputs();
        #1;
        n_total++; if (write_reg !== 5'd11 || reg_write !== 1'b1) $display("FAIL fill_pop_b got %b/%0d exp 1/11", reg_write, write_reg); else n_pass++;
        n_total++; if (mc_ready !== 1'b1) $display("FAIL fill_count_stays1 got %b exp 1", mc_ready); else n_pass++;
        step();
        n_total++; if (write_reg !== 5'd12 || write_data !== 32'hC0) $display("FAIL fill_pop_c got %0d/%h exp 12/c0", write_reg, write_data); else n_pass++;
        step();
        n_total++; if (reg_write !== 1'b0) $display("FAIL fill_drained got %b exp 0", reg_write); else n_pass++;
    endtask

    task automatic test_waw();
        mc_valid = 1'b1; mc_reg = 5'd9; mc_data = 32'h1;
        rd_reg1 = 5'd9; rd_reg2 = 5'd9;
        step();
        idle_inputs();
        wb_valid = 1'b1; wb_reg = 5'd9; wb_data = 32'h2;
        #1;
        n_total++; if (rd_busy1 !== 1'b0 || rd_busy2 !== 1'b0) $display("FAIL waw_busy_killed got %b%b exp 00", rd_busy1, rd_busy2); else n_pass++;
        step();
        idle_inputs();
        #1;
        n_total++; if (reg_write !== 1'b1 || write_data !== 32'h2) $display("FAIL waw_prim got %b/%h exp 1/2", reg_write, write_data); else n_pass++;
        step();
        n_total++; if (reg_write !== 1'b0) $display("FAIL waw_silent_pop got %b exp 0", reg_write); else n_pass++;
        step();
        n_total++; if (reg_write !== 1'b0) $display("FAIL waw_no_more got %b exp 0", reg_write); else n_pass++;
        // Kill and push to the same reg together: the pushed entry is newer and survives.
        rd_reg1 = 5'd3;
        wb_valid = 1'b1; wb_reg = 5'd3; wb_data = 32'h44;
        mc_valid = 1'b1; mc_reg = 5'd3; mc_data = 32'h33;
        step();
        idle_inputs();
        #1;
        n_total++; if (rd_busy1 !== 1'b1) $display("FAIL waw_push_survives got %b exp 1", rd_busy1); else n_pass++;
        n_total++; if (write_data !== 32'h44) $display("FAIL waw_prim_first got %h exp 44", write_data); else n_pass++;
        step();
        n_total++; if (reg_write !== 1'b1 || write_data !== 32'h33) $display("FAIL waw_pushed_written got %b/%h exp 1/33", reg_write, write_data); else n_pass++;
        step();
    endtask

    task automatic test_starvation();
        wb_valid = 1'b1; wb_reg = 5'd2; wb_data = 32'h0000_0002;
        mc_valid = 1'b1; mc_reg = 5'd20; mc_data = 32'h0000_BEEF;
        step();
        mc_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            n_total++; if (wb_stall !== 1'b0 || write_reg !== 5'd2) $display("FAIL starve_lost%0d got %b/%0d exp 0/2", i, wb_stall, write_reg); else n_pass++;
        end
        step();
        n_total++; if (wb_stall !== 1'b1) $display("FAIL starve_stall got %b exp 1", wb_stall); else n_pass++;
        wb_data = 32'h0000_DEAD;
        step();
        n_total++; if (reg_write !== 1'b1 || write_reg !== 5'd20 || write_data !== 32'hBEEF)
            $display("FAIL starve_head_written got %b/%0d/%h exp 1/20/beef", reg_write, write_reg, write_data); else n_pass++;
        n_total++; if (err !== 1'b1) $display("FAIL starve_err got %b exp 1", err); else n_pass++;
        n_total++; if (wb_stall !== 1'b0) $display("FAIL starve_stall_drop got %b exp 0", wb_stall); else n_pass++;
        idle_inputs();
        step();
        n_total++; if (reg_write !== 1'b0) $display("FAIL starve_dropped_prim got %b exp 0", reg_write); else n_pass++;
        n_total++; if (err !== 1'b1) $display("FAIL starve_err_sticky got %b exp 1", err); else n_pass++;
    endtask

    task automatic test_reset_mid();
        rd_reg1 = 5'd21; rd_reg2 = 5'd22;
        wb_valid = 1'b1; wb_reg = 5'd4; wb_data = 32'h4;
        mc_valid = 1'b1; mc_reg = 5'd21; mc_data = 32'h21;
        step();
        mc_reg = 5'd22; mc_data = 32'h22;
        step();
        idle_inputs();
        reset = 1'b1;
        #1;
        n_total++; if (mc_ready !== 1'b0) $display("FAIL rst_mid_ready got %b exp 0", mc_ready); else n_pass++;
        step();
        n_total++; if (reg_write !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'd0 || err !== 1'b0 || wb_stall !== 1'b0)
            $display("FAIL rst_mid_outputs got %b/%0d/%h/%b/%b exp 0/0/0/0/0", reg_write, write_reg, write_data, err, wb_stall); else n_pass++;
        reset = 1'b0;
        #1;
        n_total++; if (mc_ready !== 1'b1) $display("FAIL rst_mid_ready_after got %b exp 1", mc_ready); else n_pass++;
        n_total++; if (rd_busy1 !== 1'b0 || rd_busy2 !== 1'b0) $display("FAIL rst_mid_busy got %b%b exp 00", rd_busy1, rd_busy2); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++; if (reg_write !== 1'b0) $display("FAIL rst_mid_nowrite%0d got %b exp 0", i, reg_write); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_primary();
        test_secondary();
        test_fill();
        test_waw();
        test_starvation();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
